// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the 16x32 SRAM controller: default widths, depth and FSM state codes.
package mem_pkg;
  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int MEM_DEPTH  = 2 ** ADDR_W_DEF;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Two-requester request/response bundle; requester i owns slice i of the packed vectors.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-input round-robin arbiter: uncontested requests win outright, ties go to rr_ptr,
// and every grant hands priority to the other side.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o,
  output logic       gidx_o
);
  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    gnt_o  = 2'b00;
    gidx_o = 1'b0;
    if (en_i) begin
      case (valid_i)
        2'b01:   begin gnt_o = 2'b01; gidx_o = 1'b0; end
        2'b10:   begin gnt_o = 2'b10; gidx_o = 1'b1; end
        2'b11:   begin gidx_o = rr_ptr_q; gnt_o = rr_ptr_q ? 2'b10 : 2'b01; end
        default: begin gnt_o = 2'b00; gidx_o = 1'b0; end
      endcase
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|gnt_o) rr_ptr_d = ~gidx_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_ptr_q <= 1'b0;
    else        rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// SRAM controller: clears all words after reset, then shares the single port between two
// requesters. Optional per-requester grant counters under `define MEM_ARB_STATS_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_if.slave      req,
  output logic              init_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_data_out
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [1:0]        gnt;
  logic              gidx;
  logic              run_en;

  // Grants only exist in RUN and are forced off while reset is held.
  assign run_en = rst_n && (state_q == ST_RUN);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (run_en),
    .valid_i (req.req_valid),
    .gnt_o   (gnt),
    .gidx_o  (gidx)
  );

  assign req.req_ready = gnt;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_rdata = mem_data_out;
  assign init_done     = init_done_q;

  always_comb begin
    mem_addr         = init_cnt_q;
    mem_data_in      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        mem_write_enable = 1'b1;
      end else if (|gnt) begin
        mem_addr         = gidx ? req.req_addr[2*ADDR_W-1:ADDR_W] : req.req_addr[ADDR_W-1:0];
        mem_data_in      = gidx ? req.req_wdata[2*DATA_W-1:DATA_W] : req.req_wdata[DATA_W-1:0];
        mem_write_enable = req.req_write[gidx];
        mem_read_enable  = ~req.req_write[gidx];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    // gnt is one-hot, so this marks exactly the requester whose read was issued.
    rsp_valid_d = gnt & ~req.req_write;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == {ADDR_W{1'b1}}) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt[0] && (cnt0_q != 16'hFFFF)) cnt0_d = cnt0_q + 16'd1;
    if (gnt[1] && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised + directed bench for mem_arbiter: a reference model predicts grants, memory
// port activity and read data; a negedge monitor compares against a queue of expectations.
module tb_mem_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          init_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_we, mem_re;
`ifdef MEM_ARB_STATS_EN
  logic [15:0]   gc0, gc1;
`endif

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req              (bus),
    .init_done        (init_done),
    .mem_addr         (mem_addr),
    .mem_data_in      (mem_data_in),
    .mem_write_enable (mem_we),
    .mem_read_enable  (mem_re),
    .mem_data_out     (mem_data_out)
`ifdef MEM_ARB_STATS_EN
    ,
    .grant_cnt0       (gc0),
    .grant_cnt1       (gc1)
`endif
  );

  // SRAM instance: registered read, one cycle latency.
  logic [DW-1:0] sram [16];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_data_in;
    if (mem_re) mem_data_out <= sram[mem_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: contents of memory, which requester is owed priority, outstanding reads.
  typedef struct { int id; logic [DW-1:0] data; int due; } exp_t;
  exp_t          q[$];
  logic [DW-1:0] ref_mem [16];
  int            init_idx = 0;
  int            favour = 0;
  logic [1:0]    hs = 2'b00;

  always @(negedge clk) begin : monitor
    int            g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    cyc++;
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp_valid", bus.rsp_valid, 64'(2'b01 << q[0].id));
      chk("rsp_rdata", bus.rsp_rdata, q[0].data);
      void'(q.pop_front());
    end else begin
      chk("rsp_idle", bus.rsp_valid, 0);
    end
    hs = 2'b00;
    if (!rst_n) begin
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_re", mem_re, 0);
      q.delete();
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      init_idx = 0;
      favour = 0;
    end else if (init_idx < 16) begin
      chk("init_we", mem_we, 1);
      chk("init_re", mem_re, 0);
      chk("init_addr", mem_addr, init_idx);
      chk("init_data", mem_data_in, 0);
      chk("init_ready", bus.req_ready, 0);
      chk("init_done_low", init_done, 0);
      init_idx++;
    end else begin
      chk("init_done_high", init_done, 1);
      // The sole requester wins; a tie goes to whoever was not served last.
      case (bus.req_valid)
        2'b01:   g = 0;
        2'b10:   g = 1;
        2'b11:   g = favour;
        default: g = -1;
      endcase
      chk("ready", bus.req_ready, (g < 0) ? 64'd0 : 64'(2'b01 << g));
      if (g >= 0) begin
        a = (g == 1) ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
        d = (g == 1) ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
        w = bus.req_write[g];
        chk("mem_addr", mem_addr, a);
        chk("mem_we", mem_we, w);
        chk("mem_re", mem_re, !w);
        if (w) begin
          chk("mem_data_in", mem_data_in, d);
          ref_mem[a] = d;
        end else begin
          q.push_back('{g, ref_mem[a], cyc + 1});
        end
        favour = 1 - g;
        hs[g] = 1'b1;
      end else begin
        chk("idle_we", mem_we, 0);
        chk("idle_re", mem_re, 0);
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i] = v;
    bus.req_write[i] = w;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 0;
    set_req(i, 1'b1, w, a, d);
    for (int k = 0; k < 50 && !got; k++) begin
      step();
      got = hs[i];
    end
    if (!got) chk("op_timeout", 0, 1);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_init();
    int pulses = 0;
    int rise = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_we) pulses++;
      if (init_done && rise < 0) rise = k;
    end
    chk("init_pulses", pulses, 16);
    chk("init_done_cycle", rise, 16);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  initial begin
    logic [1:0] pend;
    logic [1:0] gseq [6];
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    wait_init();

    for (int a = 0; a < 16; a++) do_op(0, 1'b0, AW'(a), '0);

    // Write then immediately read back the same word.
    do_op(0, 1'b1, 4'd3, 32'hDEADBEEF);
    do_op(0, 1'b0, 4'd3, '0);
    @(negedge clk);
    chk("beef_rsp", {bus.rsp_valid, bus.rsp_rdata}, {2'b01, 32'hDEADBEEF});
    step();

    // Serve req1 once so the next tie favours req0.
    do_op(1, 1'b0, 4'd0, '0);
    set_req(0, 1'b1, 1'b0, 4'd1, '0);
    set_req(1, 1'b1, 1'b0, 4'd2, '0);
    for (int k = 0; k < 6; k++) begin
      step();
      gseq[k] = hs;
    end
    for (int k = 0; k < 6; k++) chk("alternate", gseq[k], (k % 2) ? 2'b10 : 2'b01);
    bus.req_valid = 2'b00;
    step();

    set_req(1, 1'b1, 1'b0, 4'd5, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("solo_req1", hs, 2'b10);
    end
    set_req(0, 1'b1, 1'b0, 4'd6, '0);
    step();
    chk("contested_after_solo", hs, 2'b01);
    bus.req_valid = 2'b00;
    step();

    pend = 2'b00;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          set_req(i, 1'b1, 1'($urandom_range(1)), AW'($urandom_range(3)), $urandom);
          pend[i] = 1'b1;
        end
      end
      step();
      pend = pend & ~hs;
      for (int i = 0; i < 2; i++) if (!pend[i]) bus.req_valid[i] = 1'b0;
    end
    bus.req_valid = 2'b00;
    step();

    // Reset lands while a read is being requested: no response, memory cleared.
    do_op(0, 1'b1, 4'd5, 32'h12345678);
    set_req(0, 1'b1, 1'b0, 4'd5, '0);
    rst_n = 1'b0;
    step();
    chk("rst_no_handshake", hs, 2'b00);
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    wait_init();
    do_op(0, 1'b0, 4'd5, '0);
    @(negedge clk);
    chk("reset_cleared", {bus.rsp_valid, bus.rsp_rdata}, {2'b01, 32'h0});
    step();

`ifdef MEM_ARB_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_init();
    chk("stats_clear0", gc0, 0);
    set_req(0, 1'b1, 1'b0, 4'd0, '0);
    repeat (70000) step();
    bus.req_valid = 2'b00;
    step();
    chk("stats_sat0", gc0, 16'hFFFF);
    chk("stats_cnt1", gc1, 0);
`endif

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
